// File: rtl/rs232_receive_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rs232_receive_fifo
// Description : RS232 receiver with 2-flop synchronizer, 3-sample majority
//               vote, false-start rejection and framing/overrun detection.
//               Bytes are buffered in a FIFO with a valid/ready output and
//               an active-low CTS flow-control signal back to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_receive_fifo #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rs232_txd,
  output logic       rs232_ctsn,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam longint unsigned CF = longint'(CLOCK_FREQ);
  localparam longint unsigned BR = longint'(BAUD_RATE);

  // Sample centre of bit k in clocks from the first low cycle, rounded to
  // nearest so non-integer clock/baud ratios do not accumulate error.
  function automatic longint unsigned centre_of(input longint unsigned k);
    return (CF * (2 * k + 1) + BR) / (2 * BR);
  endfunction

  localparam longint unsigned C9 = centre_of(64'd9);
  localparam int TW = $clog2(C9 + 2);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] CT0 = TW'(centre_of(64'd0));
  localparam logic [TW-1:0] CT1 = TW'(centre_of(64'd1));
  localparam logic [TW-1:0] CT2 = TW'(centre_of(64'd2));
  localparam logic [TW-1:0] CT3 = TW'(centre_of(64'd3));
  localparam logic [TW-1:0] CT4 = TW'(centre_of(64'd4));
  localparam logic [TW-1:0] CT5 = TW'(centre_of(64'd5));
  localparam logic [TW-1:0] CT6 = TW'(centre_of(64'd6));
  localparam logic [TW-1:0] CT7 = TW'(centre_of(64'd7));
  localparam logic [TW-1:0] CT8 = TW'(centre_of(64'd8));
  localparam logic [TW-1:0] CT9 = TW'(C9);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CTS_COUNT  = CW'(FIFO_DEPTH - CTS_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  // Line receiver state
  logic          sync1, rxd;
  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [3:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          samp_a, samp_a_next, samp_b, samp_b_next;
  logic [TW-1:0] centre, centre_m1, centre_p1;
  logic          majority, decide, push_req, frame_err_next;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, push_ok;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxd   <= 1'b1;
    end else begin
      sync1 <= rs232_txd;
      rxd   <= sync1;
    end
  end

  // Select the sample centre for the bit currently being received.
  always_comb begin
    centre = CT9;
    case (bit_idx)
      4'd0:    centre = CT0;
      4'd1:    centre = CT1;
      4'd2:    centre = CT2;
      4'd3:    centre = CT3;
      4'd4:    centre = CT4;
      4'd5:    centre = CT5;
      4'd6:    centre = CT6;
      4'd7:    centre = CT7;
      4'd8:    centre = CT8;
      default: centre = CT9;
    endcase
  end

  assign centre_m1 = centre - TW'(1);
  assign centre_p1 = centre + TW'(1);
  assign decide    = (timer == centre_p1);
  assign majority  = (samp_a & samp_b) | (samp_a & rxd) | (samp_b & rxd);

  // Frame state register and sampling datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      samp_a  <= samp_a_next;
      samp_b  <= samp_b_next;
    end
  end

  // Next-state logic: vote three samples around each centre, decide one
  // cycle after the centre, reject false starts, hold in BRK until idle.
  always_comb begin
    state_next     = state;
    timer_next     = timer + TW'(1);
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    samp_a_next    = (timer == centre_m1) ? rxd : samp_a;
    samp_b_next    = (timer == centre) ? rxd : samp_b;
    push_req       = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      S_IDLE: begin
        timer_next   = '0;
        bit_idx_next = '0;
        if (!rxd) begin
          state_next = S_START;
          timer_next = TW'(1);
        end
      end
      S_START: begin
        if (decide) begin
          if (majority) begin
            state_next = S_IDLE;
            timer_next = '0;
          end else begin
            state_next   = S_DATA;
            bit_idx_next = 4'd1;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shreg_next   = {majority, shreg[7:1]};
          bit_idx_next = bit_idx + 4'd1;
          if (bit_idx == 4'd8) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          timer_next = '0;
          if (majority) begin
            push_req   = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_BRK;
          end
        end
      end
      S_BRK: begin
        timer_next = '0;
        if (rxd) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = valid & ready;
  assign push_ok = push_req & (~full | pop);
  assign data    = mem[rd_ptr];

  // FIFO storage; contents need no reset since valid gates them.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy, CTS and one-cycle status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rs232_ctsn  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rs232_ctsn  <= (count >= CTS_COUNT);
      frame_error <= frame_err_next;
      overrun     <= push_req & full & ~pop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs232_receive_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_receive_fifo
// Description : Directed self-checking bench for rs232_receive_fifo at
//               16 clocks per bit, FIFO depth 4, CTS margin 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_receive_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rs232_txd = 1'b1;
  logic       ready = 1'b0;
  logic       rs232_ctsn;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;

  int compares = 0;
  int fails = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic [7:0] rise_data = 8'h00;
  logic valid_q = 1'b0;
  logic [7:0] got [$];

  rs232_receive_fifo #(
    .CLOCK_FREQ(1600000),
    .BAUD_RATE (100000),
    .FIFO_DEPTH(4),
    .CTS_MARGIN(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rs232_txd  (rs232_txd),
    .rs232_ctsn (rs232_ctsn),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // Observe outputs mid-cycle: pulses, handshakes and valid edges
  always @(negedge clock) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (valid && ready) got.push_back(data);
    if (valid && !valid_q) begin
      rise_cyc  = cyc;
      rise_data = data;
    end
    if (!valid && valid_q) fall_cyc = cyc;
    valid_q = valid;
  end

  // Run-away guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compares);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // bits[0] = start, bits[8:1] = data LSB first, bits[9] = stop
  task automatic drive_frame(input logic [9:0] bits, input int glitch, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rs232_txd = bits[c / 16] ^ (c == glitch);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_frame({1'b1, b, 1'b0}, -1, 160);
  endtask

  initial begin
    int start;
    int fe0;
    int ov0;

    // Reset state
    cycles(4);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ctsn", 32'(rs232_ctsn), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    cycles(8);

    // Single byte 0xA5 with ready high
    ready = 1'b1;
    start = cyc;
    send_byte(8'hA5);
    cycles(8);
    check("a5_latency", 32'(rise_cyc - start), 32'd156);
    check("a5_data", 32'(rise_data), 32'hA5);
    check("a5_valid_width", 32'(fall_cyc - rise_cyc), 32'd1);
    check("a5_count", 32'(got.size()), 32'd1);
    check("a5_fe", 32'(fe_cnt), 32'd0);
    check("a5_ov", 32'(ov_cnt), 32'd0);

    // Three-cycle glitch rejected, then 0x3C
    got.delete();
    rs232_txd = 1'b0;
    cycles(3);
    rs232_txd = 1'b1;
    cycles(48);
    check("glitch_no_byte", 32'(got.size()), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt), 32'd0);
    send_byte(8'h3C);
    cycles(8);
    check("3c_count", 32'(got.size()), 32'd1);
    check("3c_data", 32'(got[0]), 32'h3C);

    // Framing error followed by a long break, then 0x81
    got.delete();
    fe0 = fe_cnt;
    drive_frame({1'b0, 8'h55, 1'b0}, -1, 160);
    rs232_txd = 1'b0;
    cycles(640);
    rs232_txd = 1'b1;
    cycles(48);
    check("break_fe_once", 32'(fe_cnt - fe0), 32'd1);
    check("break_no_byte", 32'(got.size()), 32'd0);
    send_byte(8'h81);
    cycles(8);
    check("81_count", 32'(got.size()), 32'd1);
    check("81_data", 32'(got[0]), 32'h81);
    check("81_no_new_fe", 32'(fe_cnt - fe0), 32'd1);

    // Fill with ready low: CTS and overrun, then drain
    ready = 1'b0;
    got.delete();
    ov0 = ov_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    check("fill2_ctsn", 32'(rs232_ctsn), 32'd0);
    check("fill2_valid", 32'(valid), 32'd1);
    send_byte(8'h03);
    check("fill3_ctsn", 32'(rs232_ctsn), 32'd1);
    check("fill3_no_ov", 32'(ov_cnt - ov0), 32'd0);
    send_byte(8'h04);
    send_byte(8'h05);
    cycles(8);
    check("fill5_ov", 32'(ov_cnt - ov0), 32'd1);
    check("fill5_ctsn", 32'(rs232_ctsn), 32'd1);
    ready = 1'b1;
    cycles(12);
    check("drain_count", 32'(got.size()), 32'd4);
    check("drain_0", 32'(got[0]), 32'h01);
    check("drain_1", 32'(got[1]), 32'h02);
    check("drain_2", 32'(got[2]), 32'h03);
    check("drain_3", 32'(got[3]), 32'h04);
    check("drain_ctsn", 32'(rs232_ctsn), 32'd0);
    check("drain_valid", 32'(valid), 32'd0);

    // 0x00 with one inverted cycle at the centre of data bit 3
    got.delete();
    drive_frame({1'b1, 8'h00, 1'b0}, 72, 160);
    cycles(8);
    check("vote_count", 32'(got.size()), 32'd1);
    check("vote_data", 32'(got[0]), 32'h00);

    // Reset in the middle of a frame with two bytes buffered
    ready = 1'b0;
    got.delete();
    fe0 = fe_cnt;
    send_byte(8'hAA);
    send_byte(8'h55);
    cycles(4);
    check("pre_reset_valid", 32'(valid), 32'd1);
    drive_frame({1'b1, 8'hC3, 1'b0}, -1, 72);
    reset = 1'b1;
    rs232_txd = 1'b1;
    #1;
    check("mid_reset_valid", 32'(valid), 32'd0);
    check("mid_reset_ctsn", 32'(rs232_ctsn), 32'd0);
    cycles(3);
    reset = 1'b0;
    cycles(8);
    ready = 1'b1;
    send_byte(8'h7E);
    cycles(8);
    check("7e_count", 32'(got.size()), 32'd1);
    check("7e_data", 32'(got[0]), 32'h7E);
    check("7e_no_fe", 32'(fe_cnt - fe0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
`default_nettype wire
